// File: rtl/uart_fir_pkg.sv
// uart_fir_pkg: shared UART/FIR constants, types and timing helper
package uart_fir_pkg;
  localparam int CLK_FREQ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT = 115_200;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} pack_state_t;
  function automatic int bit_cycles(input int clk, input int baud);
    return clk / baud;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with exact occupancy count
module sample_fifo #(
  parameter int Width = 16,
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [Width-1:0]       wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [Width-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign rd = rd_en && !empty;
  assign wr = wr_en && (!full || rd);
  assign full = count == (AW+1)'(Depth);
  assign empty = count == '0;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/rx_sample_packer.sv
// rx_sample_packer: packs UART bytes into little-endian samples with holdoff, timeout and FIFO buffering
module rx_sample_packer
  import uart_fir_pkg::*;
#(
  parameter int ClkFrequency = CLK_FREQ_DEFAULT,
  parameter int Baud = BAUD_DEFAULT,
  parameter int DataWidth = 16,
  parameter int FifoDepth = 8,
  parameter int TimeoutBytes = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic [DataWidth-1:0]         sample_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic                         overflow,
  output logic                         timeout_err
);
  localparam int BitCycles = bit_cycles(ClkFrequency, Baud);
  localparam int Bps = DataWidth / 8;
  localparam int TimeoutCycles = TimeoutBytes * 10 * BitCycles;
  localparam int HW = $clog2(BitCycles + 1);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam int IW = Bps > 1 ? $clog2(Bps) : 1;
  pack_state_t state, state_n;
  logic valid_q, accept, last, timeout, full, empty, pop;
  logic [HW-1:0] hold;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;
  logic [DataWidth-1:0] data_q;
  assign accept = byte_valid && !valid_q && hold == '0 && state != PUSH;
  assign last = idx == IW'(Bps - 1);
  assign timeout = state == COLLECT && !accept && tcnt == TW'(TimeoutCycles - 1);
  assign sample_valid = !empty;
  assign pop = sample_valid && sample_ready;
  always_comb
    state_n = state == PUSH ? IDLE : accept ? (last ? PUSH : COLLECT) : timeout ? IDLE : state;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      hold <= '0;
      tcnt <= '0;
      idx <= '0;
      data_q <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid_q <= byte_valid;
      hold <= accept ? HW'(BitCycles) : (hold != '0 ? hold - HW'(1) : hold);
      tcnt <= (accept || timeout || state != COLLECT) ? '0 : tcnt + TW'(1);
      if (accept) begin
        data_q[8*idx +: 8] <= byte_data;
        idx <= last ? '0 : idx + IW'(1);
      end else if (timeout) idx <= '0;
      timeout_err <= timeout;
      if (state == PUSH && full && !pop) overflow <= 1'b1;
    end
  end
  sample_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(state == PUSH),
    .wr_data(data_q),
    .full(full),
    .rd_en(sample_ready),
    .rd_data(sample_data),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_rx_sample_packer.sv
// tb_rx_sample_packer: scoreboard bench for byte packing, holdoff, timeout, overflow and reset
module tb_rx_sample_packer;
  logic clk = 0, rst = 1, byte_valid = 0, sample_ready = 0;
  logic [7:0] byte_data = 0;
  logic [15:0] sample_data;
  logic sample_valid, overflow, timeout_err;
  logic [3:0] fifo_count;
  int checks = 0, errors = 0, to_cnt = 0, t0;
  logic [15:0] exp_q[$];
  rx_sample_packer #(
    .ClkFrequency(1_000_000), .Baud(100_000), .DataWidth(16), .FifoDepth(8), .TimeoutBytes(3)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .fifo_count(fifo_count), .overflow(overflow), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (timeout_err) to_cnt++;
    if (!rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample got %h expected none", sample_data);
      end else check("sample", sample_data, exp_q.pop_front());
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1;
    byte_data = b;
    tick(3);
    byte_valid = 0;
    tick(97);
  endtask
  task automatic send_sample(input logic [15:0] s);
    send_byte(s[7:0]);
    send_byte(s[15:8]);
  endtask
  task automatic glitch_byte(input logic [7:0] b);
    repeat (3) begin
      byte_valid = 1;
      byte_data = b;
      tick(1);
      byte_valid = 0;
      tick(1);
    end
    tick(94);
  endtask
  initial begin
    tick(3);
    @(negedge clk);
    check("rst_valid", sample_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_data", sample_data, 0);
    tick(1);
    rst = 0;
    tick(5);
    sample_ready = 1;
    exp_q.push_back(16'h1234);
    send_byte(8'h34);
    byte_valid = 1;
    byte_data = 8'h12;
    @(negedge clk);
    @(negedge clk);
    check("t1_push_cycle_valid", sample_valid, 0);
    @(negedge clk);
    check("t1_valid_high", sample_valid, 1);
    check("t1_count_one", fifo_count, 1);
    @(negedge clk);
    check("t1_valid_low", sample_valid, 0);
    check("t1_count_zero", fifo_count, 0);
    tick(1);
    byte_valid = 0;
    tick(96);
    check("t1_drain", exp_q.size(), 0);
    exp_q.push_back(16'h55AA);
    glitch_byte(8'hAA);
    send_byte(8'h55);
    tick(5);
    check("t2_drain", exp_q.size(), 0);
    t0 = to_cnt;
    exp_q.push_back(16'h3322);
    send_byte(8'h11);
    tick(350);
    check("t3_timeout_pulse", to_cnt - t0, 1);
    send_byte(8'h22);
    send_byte(8'h33);
    tick(5);
    check("t3_drain", exp_q.size(), 0);
    check("t3_timeout_total", to_cnt - t0, 1);
    sample_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      send_sample(16'h0100 + 16'(i));
    end
    check("t5_full_count", fifo_count, 8);
    check("t5_full_overflow", overflow, 0);
    exp_q.push_back(16'h0109);
    send_byte(8'h09);
    byte_valid = 1;
    byte_data = 8'h01;
    tick(1);
    sample_ready = 1;
    tick(1);
    sample_ready = 0;
    byte_valid = 0;
    tick(97);
    check("t5_push_pop_count", fifo_count, 8);
    check("t5_push_pop_overflow", overflow, 0);
    sample_ready = 1;
    tick(12);
    check("t5_drain", exp_q.size(), 0);
    check("t5_empty", fifo_count, 0);
    rst = 1;
    tick(2);
    rst = 0;
    sample_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(16'(i));
      send_sample(16'(i));
    end
    check("t4_count", fifo_count, 8);
    check("t4_overflow", overflow, 1);
    sample_ready = 1;
    tick(12);
    check("t4_drain", exp_q.size(), 0);
    check("t4_empty", fifo_count, 0);
    check("t4_overflow_sticky", overflow, 1);
    t0 = to_cnt;
    send_byte(8'h77);
    rst = 1;
    tick(2);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_count", fifo_count, 0);
    rst = 0;
    tick(2);
    exp_q.push_back(16'hABCD);
    send_byte(8'hCD);
    send_byte(8'hAB);
    tick(400);
    check("t6_no_timeout", to_cnt - t0, 0);
    check("t6_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_sample_packer.md
# rx_sample_packer

Assembles the byte stream produced by the UART receiver into signed `DataWidth`-bit little-endian samples and buffers them in a small first-word-fall-through FIFO for the FIR filter input. It rejects repeated ready pulses from a single UART frame. It discards partially assembled samples after an inter-byte timeout, so a lost byte cannot permanently swap byte order. It sits between the UART receiver and the FIR filter.

## Interface
- `ClkFrequency`, 50000000, system clock in Hz.
- `Baud`, 115200, UART bit rate.
- `DataWidth`, 16, sample width. Must be a multiple of 8 in the range 8..32.
- `FifoDepth`, 8, sample FIFO depth. Must be a power of two, at least 2.
- `TimeoutBytes`, 3, inter-byte timeout in frame times. One frame is 10 bits.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `byte_valid` input 1: receiver data-ready strobe. May pulse more than once per frame.
- `byte_data` input 8: receiver data. Stable while `byte_valid` is high.
- `sample_data` output DataWidth: FIFO head sample. Valid only while `sample_valid` is 1.
- `sample_valid` output 1: FIFO not empty.
- `sample_ready` input 1: FIR accepts the head sample.
- `fifo_count` output $clog2(FifoDepth)+1: number of samples stored.
- `overflow` output 1: sticky; set when a sample is dropped because the FIFO is full.
- `timeout_err` output 1: one-cycle pulse when a partial sample is discarded.

## Operation
- Derived constants:
  - `BitCycles = ClkFrequency/Baud`.
  - `BytesPerSample = DataWidth/8`.
  - `TimeoutCycles = TimeoutBytes*10*BitCycles`.
- Byte accept rule:
  - A byte is accepted at the first clock edge where `byte_valid` is 1 and was 0 on the previous edge.
  - The byte must also fall outside the holdoff window.
  - Holdoff: after an accept, further rising edges are ignored for `BitCycles` cycles.
- FSM states:
  - IDLE: no bytes held.
  - COLLECT: between 1 and `BytesPerSample-1` bytes held.
  - PUSH: one cycle, assembled sample written to the FIFO.
- Transitions:
  - IDLE to COLLECT on accept. The byte goes into bits [7:0] and byte index becomes 1.
  - COLLECT stays in COLLECT on accept. The byte is written into bits [8*idx+7:8*idx] and idx is incremented.
  - COLLECT to PUSH when the final byte is accepted.
  - COLLECT to IDLE on timeout. `timeout_err` pulses, the partial data is discarded and idx is reset to 0.
  - When `BytesPerSample`=1, IDLE goes directly to PUSH.
  - PUSH always returns to IDLE.
  - An accept arriving during PUSH is ignored. It cannot occur within holdoff.
- Timeout counter: cleared on every accept and counts only in COLLECT. Timeout fires when the count equals `TimeoutCycles-1`. If timeout and accept fall on the same cycle, the accept wins and the counter is cleared.
- FIFO write: occurs in PUSH.
  - If the FIFO is full and no pop occurs that cycle, the sample is dropped and `overflow` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the write succeeds and `overflow` is unchanged.
- FIFO read: a pop occurs when `sample_valid` and `sample_ready` are both 1. `sample_ready` while empty has no effect.
- Pointer arithmetic: pointers wrap modulo `FifoDepth`. `fifo_count` is exact, from 0 to `FifoDepth`.
- Sample bytes are raw; no sign manipulation is applied. The FIR treats `sample_data` as two's complement.

## Timing
- Reset values:
  - all outputs 0
  - FSM in IDLE, idx 0
  - holdoff and timeout counters 0
  - FIFO empty
- `overflow` is cleared only by `rst`.
- Latency: final byte's `byte_valid` rising edge accepted at edge k, PUSH at k+1, `sample_valid`=1 and `fifo_count` incremented after edge k+1.
- A pop at edge j updates the head and count after edge j. When push and pop occur on the same edge, the count is unchanged.
- `timeout_err` is high for exactly the one cycle after the detecting edge.
- Reset mid-sample: all partial data and FIFO contents are lost and no `timeout_err` is produced.
- Throughput: one sample per `BytesPerSample` frames. The FIFO absorbs up to `FifoDepth` samples of FIR stall.

## Structure
- Shared package `uart_fir_pkg` holds:
  - `CLK_FREQ_DEFAULT` and `BAUD_DEFAULT`
  - function `bit_cycles(clk, baud)`
  - typedef `sample_t` (signed [15:0]), shared with the FIR
- Sub-module `sample_fifo` (parameters `Width`, `Depth`):
  - synchronous FWFT FIFO
  - ports `wr_en`/`wr_data`/`full` and `rd_en`/`rd_data`/`empty`, plus `count`
- The top level holds the FSM, the edge/holdoff logic and the timeout logic.

## Test plan
- Bytes 0x34 then 0x12, frames spaced normally, `sample_ready`=1 -> `sample_data`=0x1234 with `sample_valid` high one cycle at PUSH+1, then low. `fifo_count` goes 1 then 0.
- `byte_valid` pulsed 3 times within `BitCycles` for byte 0xAA, then 0x55 after a frame gap -> exactly one sample, 0x55AA.
- 0x11, then a gap longer than `TimeoutCycles`, then 0x22, 0x33 -> one `timeout_err` pulse and a single sample 0x3322.
- `sample_ready`=0, send 9 samples 0x0001..0x0009 -> `fifo_count`=8 and `overflow`=1. Popping then yields 0x0001..0x0008, and 0x0009 is absent.
- FIFO full, PUSH on the same edge as a pop -> sample accepted, `fifo_count` stays 8, `overflow` stays 0.
- `rst` asserted after the first byte of a pair, then a fresh pair 0xCD, 0xAB -> the output is 0xABCD only, with no `timeout_err`.
